wb_uart_master: RTL and testbench

- Wishbone initiator driven by a serial byte stream: the debug/loader path that lets a host read and write any bus slave (RAM, UART registers) over the serial link.
- Sits between a UART byte receiver/transmitter pair and the shared 16-bit bus; bus access is arbitrated outside this block.
- Parses fixed-format command packets, runs one single-beat bus cycle per packet, and returns a response packet.

---
 rtl/wb_uart_master.sv | 200 ++++++++++++++++++++
 tb/tb_wb_uart_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_uart_master.sv
// Serial-command driven 16-bit Wishbone initiator: parses write/read packets from the UART
// receiver, runs one single-beat bus cycle, returns a response. Optional macro: WB_UART_MASTER_ACK_EN.
module wb_uart_master #(
  parameter int IDLE_TIMEOUT = 65535,
  parameter int READ_LAT     = 1,
  parameter int ACK_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] adr_o,
  output logic [15:0] dat_o,
  input  logic [15:0] dat_i,
  output logic        we_o,
  output logic        sel_o,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

`ifdef WB_UART_MASTER_ACK_EN
  localparam bit ACK_EN = 1'b1;
`else
  localparam bit ACK_EN = 1'b0;
`endif

  // Last BUS cycle index: READ_LAT in fixed mode, ACK_TIMEOUT-1 when waiting on ack_i.
  localparam int ACK_LAST = (ACK_TIMEOUT > 1) ? ACK_TIMEOUT - 1 : 0;
  localparam int BUS_MAX  = ACK_EN ? ACK_LAST : READ_LAT;
  localparam int BCNT_W   = (BUS_MAX > 0) ? $clog2(BUS_MAX + 1) : 1;
  localparam int TMR_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [BCNT_W-1:0] BUS_LAST = BCNT_W'(BUS_MAX);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADR_H  = 3'd1,
    ST_ADR_L  = 3'd2,
    ST_DAT_H  = 3'd3,
    ST_DAT_L  = 3'd4,
    ST_BUS    = 3'd5,
    ST_RESP_H = 3'd6,
    ST_RESP_L = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [15:0]       adr_q, adr_d;
  logic [15:0]       dat_q, dat_d;
  logic [7:0]        rhi_q, rhi_d;   // read data high byte, sent in RESP_H
  logic [7:0]        resp_q, resp_d; // byte sent in RESP_L: status code or read data low byte
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              err_q, err_d;

`ifndef WB_UART_MASTER_ACK_EN
  logic unused_ack;
  assign unused_ack = ack_i;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      rhi_q   <= '0;
      resp_q  <= '0;
      tmr_q   <= '0;
      bcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rhi_q   <= rhi_d;
      resp_q  <= resp_d;
      tmr_q   <= tmr_d;
      bcnt_q  <= bcnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rhi_d   = rhi_q;
    resp_d  = resp_q;
    tmr_d   = tmr_q;
    bcnt_d  = bcnt_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            we_d    = (rx_data == CMD_WR);
            state_d = ST_ADR_H;
          end else begin
            resp_d  = RSP_NAK;
            err_d   = 1'b1;
            state_d = ST_RESP_L;
          end
        end
      end

      ST_ADR_H, ST_ADR_L, ST_DAT_H, ST_DAT_L: begin
        // A byte arriving on the timeout cycle still wins and restarts the timer.
        if (rx_valid) begin
          tmr_d  = '0;
          bcnt_d = '0;
          case (state_q)
            ST_ADR_H: begin
              adr_d[15:8] = rx_data;
              state_d     = ST_ADR_L;
            end
            ST_ADR_L: begin
              adr_d[7:0] = rx_data;
              state_d    = we_q ? ST_DAT_H : ST_BUS;
            end
            ST_DAT_H: begin
              dat_d[15:8] = rx_data;
              state_d     = ST_DAT_L;
            end
            default: begin
              dat_d[7:0] = rx_data;
              state_d    = ST_BUS;
            end
          endcase
        end else if (tmr_q == TMR_LAST) begin
          tmr_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      ST_BUS: begin
        if (rx_valid) err_d = 1'b1;
        bcnt_d = bcnt_q + 1'b1;
`ifdef WB_UART_MASTER_ACK_EN
        if (ack_i) begin
          rhi_d   = dat_i[15:8];
          resp_d  = we_q ? RSP_ACK : dat_i[7:0];
          state_d = we_q ? ST_RESP_L : ST_RESP_H;
        end else if (bcnt_q == BUS_LAST) begin
          resp_d  = RSP_NAK;
          err_d   = 1'b1;
          state_d = ST_RESP_L;
        end
`else
        if (bcnt_q == BUS_LAST) begin
          rhi_d   = dat_i[15:8];
          resp_d  = we_q ? RSP_ACK : dat_i[7:0];
          state_d = we_q ? ST_RESP_L : ST_RESP_H;
        end
`endif
      end

      ST_RESP_H: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) state_d = ST_RESP_L;
      end

      default: begin
        if (rx_valid) err_d = 1'b1;
        if (tx_ready) state_d = ST_IDLE;
      end
    endcase
  end

  // Bus strobes decode straight from the state so an async reset drops them at once.
  assign cyc_o    = (state_q == ST_BUS);
  assign stb_o    = cyc_o;
  assign sel_o    = cyc_o;
  assign we_o     = cyc_o & we_q;
  assign adr_o    = adr_q;
  assign dat_o    = dat_q;
  assign tx_valid = (state_q == ST_RESP_H) || (state_q == ST_RESP_L);
  assign tx_data  = (state_q == ST_RESP_H) ? rhi_q : resp_q;
  assign busy_o   = (state_q != ST_IDLE);
  assign err_o    = err_q;

endmodule

// File: tb/tb_wb_uart_master.sv
// Directed bench for wb_uart_master: table of packets plus hand-written timeout/reset/backpressure
// sequences. With WB_UART_MASTER_ACK_EN defined the ack-timeout path is exercised as well.
module tb_wb_uart_master;
  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [15:0] adr_o, dat_o;
  logic [15:0] dat_i = 16'hDEAD;
  logic        we_o, sel_o, stb_o, cyc_o, busy_o, err_o;
  logic        ack_i = 1'b0;

  wb_uart_master #(.IDLE_TIMEOUT(16), .READ_LAT(READ_LAT), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int err_cnt = 0;
  int cyc_cnt = 0;

  always @(negedge clk) begin
    if (err_o) err_cnt = err_cnt + 1;
    if (cyc_o) cyc_cnt = cyc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic [39:0] pkt;
    int          nb;
    logic [15:0] slave;
    logic [15:0] adr;
    logic [15:0] dat;
    logic        we;
    int          stb;
    logic [15:0] rsp;
    int          nr;
    int          errs;
  } vec_t;

  int          bus_n;
  logic [15:0] bus_adr, bus_dat;
  logic        bus_we, bus_ok;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_pkt(input logic [39:0] pkt, input int nb);
    for (int i = 0; i < nb; i++) send_byte(pkt[39-8*i -: 8]);
  endtask

  // ack_mode: 0 = ack with data on the READ_LAT cycle, 1 = never ack, 2 = ack held high.
  task automatic run_bus(input logic [15:0] slave, input int ack_mode);
    bus_n = 0; bus_adr = '0; bus_dat = '0; bus_we = 1'b0; bus_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!stb_o) break;
      if (bus_n == 0) begin
        bus_adr = adr_o; bus_dat = dat_o; bus_we = we_o;
      end else if (adr_o !== bus_adr || dat_o !== bus_dat || we_o !== bus_we) begin
        bus_ok = 1'b0;
      end
      if (cyc_o !== 1'b1 || sel_o !== 1'b1) bus_ok = 1'b0;
      dat_i = (bus_n == READ_LAT) ? slave : 16'hDEAD;
      ack_i = (ack_mode == 2) || (ack_mode == 0 && bus_n == READ_LAT);
      bus_n++;
      tick();
    end
    dat_i = 16'hDEAD;
    ack_i = 1'b0;
    if (cyc_o !== 1'b0 || sel_o !== 1'b0) bus_ok = 1'b0;
  endtask

  task automatic get_resp(input int nr, output logic [15:0] got, output int ngot);
    int w;
    got = '0; ngot = 0;
    for (int k = 0; k < nr; k++) begin
      w = 0;
      while (!tx_valid && w < 10) begin tick(); w++; end
      if (!tx_valid) break;
      got = {got[7:0], tx_data};
      ngot++;
      tx_ready = 1'b1;
      tick();
      tx_ready = 1'b0;
    end
  endtask

  task automatic finish_vec(input vec_t v, input int e0, input int c0);
    logic [15:0] got;
    int ngot;
    run_bus(v.slave, 0);
    get_resp(v.nr, got, ngot);
    check({v.name, " stb_cycles"}, bus_n, v.stb);
    if (v.stb > 0) begin
      check({v.name, " adr_o"}, 32'(bus_adr), 32'(v.adr));
      check({v.name, " we_o"}, 32'(bus_we), 32'(v.we));
      check({v.name, " bus_stable"}, 32'(bus_ok), 32'd1);
      if (v.we) check({v.name, " dat_o"}, 32'(bus_dat), 32'(v.dat));
    end
    check({v.name, " resp_bytes"}, ngot, v.nr);
    check({v.name, " resp"}, 32'(got), 32'(v.rsp));
    check({v.name, " err_pulses"}, err_cnt - e0, v.errs);
    check({v.name, " cyc_cycles"}, cyc_cnt - c0, v.stb);
    check({v.name, " idle_after"}, 32'(busy_o), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int e0, c0;
    e0 = err_cnt; c0 = cyc_cnt;
    send_pkt(v.pkt, v.nb);
    finish_vec(v, e0, c0);
  endtask

  vec_t vecs[6];
  vec_t hv;

  initial begin
    int e0, c0, waited;
    logic [15:0] got;
    int ngot;

    vecs[0] = '{"wr_0010", 40'h57_00_10_BE_EF, 5, 16'h0000, 16'h0010, 16'hBEEF, 1'b1, 2, 16'h0006, 1, 0};
    vecs[1] = '{"rd_F000", 40'h52_F0_00_00_00, 3, 16'h1234, 16'hF000, 16'h0000, 1'b0, 2, 16'h1234, 2, 0};
    vecs[2] = '{"bad_41",  40'h41_00_00_00_00, 1, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 16'h0015, 1, 1};
    vecs[3] = '{"wr_FFFF", 40'h57_FF_FF_00_01, 5, 16'h0000, 16'hFFFF, 16'h0001, 1'b1, 2, 16'h0006, 1, 0};
    vecs[4] = '{"rd_1234", 40'h52_12_34_00_00, 3, 16'hA55A, 16'h1234, 16'h0000, 1'b0, 2, 16'hA55A, 2, 0};
    vecs[5] = '{"rd_FFFF", 40'h52_FF_FF_00_00, 3, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 2, 16'h0000, 2, 0};

    #2 rst_n = 1'b0;
    tick(); tick();
    check("reset tx", {23'd0, tx_valid, tx_data}, 32'd0);
    check("reset bus", {adr_o, dat_o}, 32'd0);
    check("reset strobes", {27'd0, we_o, sel_o, stb_o, cyc_o, busy_o}, 32'd0);
    check("reset err", 32'(err_o), 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle busy", 32'(busy_o), 32'd0);

    // Back-to-back: each packet starts in the first IDLE cycle after the previous response.
    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // tx backpressure, with a stray byte dropped while the response is pending.
    e0 = err_cnt;
    send_pkt(40'h52_F0_00_00_00, 3);
    run_bus(16'h1234, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold tx_valid", 32'(tx_valid), 32'd1);
      check("hold tx_data", 32'(tx_data), 32'h12);
      if (i == 2) begin rx_data = 8'h57; rx_valid = 1'b1; end
      tick();
      rx_valid = 1'b0;
    end
    check("stray err", err_cnt - e0, 1);
    get_resp(2, got, ngot);
    check("hold resp", 32'(got), 32'h1234);
    check("hold idle", 32'(busy_o), 32'd0);

    // Inter-byte timeout after a partial write packet.
    e0 = err_cnt;
    send_pkt(40'h57_00_00_00_00, 2);
    for (int i = 0; i < 14; i++) tick();
    check("tmo early busy", 32'(busy_o), 32'd1);
    check("tmo early err", err_cnt - e0, 0);
    waited = 14;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (err_cnt != e0) break;
      waited++;
    end
    check("tmo idle cycles", waited, 16);
    check("tmo err", err_cnt - e0, 1);
    check("tmo no resp", {30'd0, busy_o, tx_valid}, 32'd0);
    hv = '{"after_tmo", 40'h52_00_00_00_00, 3, 16'hBEEF, 16'h0000, 16'h0000, 1'b0, 2, 16'hBEEF, 2, 0};
    run_vec(hv);

    // A byte landing on the timeout cycle is taken and the packet completes.
    e0 = err_cnt; c0 = cyc_cnt;
    send_byte(8'h57);
    for (int i = 0; i < 15; i++) tick();
    send_pkt(40'h00_20_AA_55_00, 4);
    hv = '{"tmo_race", 40'h0, 0, 16'h0000, 16'h0020, 16'hAA55, 1'b1, 2, 16'h0006, 1, 0};
    finish_vec(hv, e0, c0);

    // Async reset during the bus cycle.
    send_pkt(40'h52_00_01_00_00, 3);
    check("pre-reset stb", 32'(stb_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst cyc/stb/sel", {29'd0, cyc_o, stb_o, sel_o}, 32'd0);
    check("rst tx/busy", {30'd0, tx_valid, busy_o}, 32'd0);
    check("rst adr", 32'(adr_o), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    hv = '{"after_rst", 40'h52_00_01_00_00, 3, 16'hCAFE, 16'h0001, 16'h0000, 1'b0, 2, 16'hCAFE, 2, 0};
    run_vec(hv);

`ifdef WB_UART_MASTER_ACK_EN
    // Slave never acknowledges: bounded wait, NAK, error pulse.
    e0 = err_cnt;
    send_pkt(40'h52_00_05_00_00, 3);
    run_bus(16'h5A5A, 1);
    check("ack_tmo stb_cycles", bus_n, 8);
    get_resp(1, got, ngot);
    check("ack_tmo resp", 32'(got), 32'h15);
    check("ack_tmo err", err_cnt - e0, 1);
    check("ack_tmo idle", 32'(busy_o), 32'd0);
`else
    // ack_i held high from the first cycle must not shorten fixed-latency timing.
    e0 = err_cnt;
    send_pkt(40'h52_00_05_00_00, 3);
    run_bus(16'h5A5A, 2);
    check("ack_ign stb_cycles", bus_n, READ_LAT + 1);
    get_resp(2, got, ngot);
    check("ack_ign resp", 32'(got), 32'h5A5A);
    check("ack_ign err", err_cnt - e0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
